prpg_checker: RTL and testbench

- Receive-side companion to the 3-bit LFSR pattern generator (PRPG).
- Samples the generator's parallel output stream, self-synchronises by seeding its own LFSR model from a received word, then predicts each next word and compares it with the one received.
- Reports lock status, per-word errors, a saturating error count, loss of sync and a once-per-period marker.
- Used in self-test benches and BIST loops to confirm that the PRPG stream arrives intact.

---
 rtl/prpg_checker.sv | 140 ++++++++++++++
 tb/tb_prpg_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prpg_checker.sv
// Receive-side checker for the 3-bit LFSR pattern generator: self-seeds from the
// incoming stream, predicts each next word and reports lock, errors and loss of sync.
module prpg_checker #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] TAPS     = 3'b110,
    parameter logic [WIDTH-1:0] SEED     = 3'b111,
    parameter int               LOCK_CNT = 4,
    parameter int               MISS_MAX = 3,
    parameter int               ERR_W    = 8
) (
    input  logic             clk,
    input  logic             set,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             locked,
    output logic             err,
    output logic             lost,
    output logic             period_mark,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(MISS_MAX + 1);
    localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [MS_W-1:0]  MISS_LAST = MS_W'(MISS_MAX - 1);
    localparam logic [ERR_W-1:0] ERR_SAT   = '1;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] predict_q, predict_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [MS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;
    logic             period_mark_q, period_mark_d;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & TAPS)};
    endfunction

    // In LOCKED the prediction free-runs (flywheel) and is never reseeded by din.
    always_comb begin
        state_d       = state_q;
        predict_d     = predict_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        err_cnt_d     = err_cnt_q;
        locked_d      = locked_q;
        err_d         = 1'b0;
        lost_d        = 1'b0;
        period_mark_d = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (din != '0) begin
                        predict_d   = nxt(din);
                        match_cnt_d = '0;
                        state_d     = SYNC;
                    end
                end
                SYNC: begin
                    if (din == predict_q) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        predict_d   = nxt(din);
                        if (match_cnt_q == LOCK_LAST) begin
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                            miss_cnt_d = '0;
                        end
                    end else if (din == '0) begin
                        state_d = HUNT;
                    end else begin
                        predict_d   = nxt(din);
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    predict_d = nxt(predict_q);
                    if (din == predict_q) begin
                        miss_cnt_d    = '0;
                        period_mark_d = (din == SEED);
                    end else begin
                        err_d      = 1'b1;
                        miss_cnt_d = miss_cnt_q + 1'b1;
                        if (err_cnt_q != ERR_SAT) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (set) begin
            state_q       <= HUNT;
            predict_q     <= '0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            err_cnt_q     <= '0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            lost_q        <= 1'b0;
            period_mark_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            predict_q     <= predict_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            err_cnt_q     <= err_cnt_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            lost_q        <= lost_d;
            period_mark_q <= period_mark_d;
        end
    end

    assign locked      = locked_q;
    assign err         = err_q;
    assign lost        = lost_q;
    assign period_mark = period_mark_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_prpg_checker.sv
// Bench for prpg_checker: a default instance and a saturation instance (MISS_MAX=255,
// ERR_W=4) share one stimulus stream; expected outputs are queued per driven word.
module tb_prpg_checker;

    logic       clk = 1'b0;
    logic       set = 1'b0;
    logic       din_valid = 1'b0;
    logic [2:0] din = 3'b000;

    logic       locked_a, err_a, lost_a, period_mark_a;
    logic [7:0] err_cnt_a;
    logic       locked_b, err_b, lost_b, period_mark_b;
    logic [3:0] err_cnt_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prpg_checker dut_a (
        .clk(clk), .set(set), .din_valid(din_valid), .din(din),
        .locked(locked_a), .err(err_a), .lost(lost_a),
        .period_mark(period_mark_a), .err_cnt(err_cnt_a)
    );

    prpg_checker #(.MISS_MAX(255), .ERR_W(4)) dut_b (
        .clk(clk), .set(set), .din_valid(din_valid), .din(din),
        .locked(locked_b), .err(err_b), .lost(lost_b),
        .period_mark(period_mark_b), .err_cnt(err_cnt_b)
    );

    typedef struct {
        int         st;
        logic [2:0] pred;
        int         match;
        int         miss;
        int         errcnt;
        logic       locked;
        logic       err;
        logic       lost;
        logic       pm;
        int         miss_max;
        int         err_max;
    } model_t;

    typedef struct packed {
        logic       locked_a, err_a, lost_a, pm_a;
        logic [7:0] cnt_a;
        logic       locked_b, err_b, lost_b, pm_b;
        logic [3:0] cnt_b;
    } exp_t;

    exp_t   exp_q[$];
    model_t m_a, m_b;
    logic [2:0] seq [7] = '{3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101, 3'b011};
    int gi = 0;

    function automatic logic [2:0] lfsr_next(input logic [2:0] x);
        return {x[1:0], ^(x & 3'b110)};
    endfunction

    // Reference behaviour: 0=HUNT, 1=SYNC, 2=LOCKED.
    function automatic model_t modelStep(input model_t m, input logic s, input logic v,
                                         input logic [2:0] d);
        model_t r = m;
        r.err = 1'b0;
        r.lost = 1'b0;
        r.pm = 1'b0;
        if (s) begin
            r.st = 0; r.pred = 3'b000; r.match = 0; r.miss = 0;
            r.errcnt = 0; r.locked = 1'b0;
        end else if (v) begin
            if (r.st == 0) begin
                if (d != 3'b000) begin
                    r.pred = lfsr_next(d); r.match = 0; r.st = 1;
                end
            end else if (r.st == 1) begin
                if (d == m.pred) begin
                    r.match = m.match + 1;
                    r.pred = lfsr_next(d);
                    if (r.match == 4) begin
                        r.st = 2; r.locked = 1'b1; r.miss = 0;
                    end
                end else if (d == 3'b000) begin
                    r.st = 0;
                end else begin
                    r.pred = lfsr_next(d); r.match = 0;
                end
            end else begin
                r.pred = lfsr_next(m.pred);
                if (d == m.pred) begin
                    r.miss = 0;
                    r.pm = (d == 3'b111);
                end else begin
                    r.err = 1'b1;
                    r.miss = m.miss + 1;
                    if (m.errcnt < m.err_max) r.errcnt = m.errcnt + 1;
                    if (r.miss == m.miss_max) begin
                        r.st = 0; r.locked = 1'b0; r.lost = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [2:0] d);
        exp_t e;
        set = s;
        din_valid = v;
        din = d;
        m_a = modelStep(m_a, s, v, d);
        m_b = modelStep(m_b, s, v, d);
        e.locked_a = m_a.locked; e.err_a = m_a.err; e.lost_a = m_a.lost; e.pm_a = m_a.pm;
        e.cnt_a = 8'(m_a.errcnt);
        e.locked_b = m_b.locked; e.err_b = m_b.err; e.lost_b = m_b.lost; e.pm_b = m_b.pm;
        e.cnt_b = 4'(m_b.errcnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput("locked_a", 32'(locked_a), 32'(e.locked_a));
        checkOutput("err_a", 32'(err_a), 32'(e.err_a));
        checkOutput("lost_a", 32'(lost_a), 32'(e.lost_a));
        checkOutput("period_mark_a", 32'(period_mark_a), 32'(e.pm_a));
        checkOutput("err_cnt_a", 32'(err_cnt_a), 32'(e.cnt_a));
        checkOutput("locked_b", 32'(locked_b), 32'(e.locked_b));
        checkOutput("err_b", 32'(err_b), 32'(e.err_b));
        checkOutput("lost_b", 32'(lost_b), 32'(e.lost_b));
        checkOutput("period_mark_b", 32'(period_mark_b), 32'(e.pm_b));
        checkOutput("err_cnt_b", 32'(err_cnt_b), 32'(e.cnt_b));
    endtask

    task automatic sendGood();
        applyStimulus(1'b0, 1'b1, seq[gi]);
        gi = (gi + 1) % 7;
    endtask

    // A nonzero word that differs from the one the stream expects next.
    task automatic sendBad();
        logic [2:0] w;
        w = (seq[gi] == 3'b111) ? 3'b001 : 3'b111;
        applyStimulus(1'b0, 1'b1, w);
        gi = (gi + 1) % 7;
    endtask

    initial begin
        m_a = '{st: 0, pred: 3'b000, match: 0, miss: 0, errcnt: 0, locked: 1'b0,
                err: 1'b0, lost: 1'b0, pm: 1'b0, miss_max: 3, err_max: 255};
        m_b = '{st: 0, pred: 3'b000, match: 0, miss: 0, errcnt: 0, locked: 1'b0,
                err: 1'b0, lost: 1'b0, pm: 1'b0, miss_max: 255, err_max: 15};
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 3'b000);
        checkOutput("reset_locked", 32'(locked_a), 32'd0);
        checkOutput("reset_err_cnt", 32'(err_cnt_a), 32'd0);

        gi = 0;
        for (int i = 0; i < 4; i++) sendGood();
        checkOutput("not_locked_after4", 32'(locked_a), 32'd0);
        sendGood();
        checkOutput("locked_after5", 32'(locked_a), 32'd1);
        for (int i = 0; i < 16; i++) sendGood();
        checkOutput("lock_err_cnt_zero", 32'(err_cnt_a), 32'd0);

        while (seq[gi] != 3'b010) sendGood();
        applyStimulus(1'b0, 1'b1, 3'b011);
        gi = (gi + 1) % 7;
        checkOutput("single_err_pulse", 32'(err_a), 32'd1);
        checkOutput("single_err_cnt", 32'(err_cnt_a), 32'd1);
        checkOutput("single_err_locked", 32'(locked_a), 32'd1);
        sendGood();
        checkOutput("flywheel_no_err", 32'(err_a), 32'd0);

        for (int i = 0; i < 3; i++) sendBad();
        checkOutput("loss_lost_pulse", 32'(lost_a), 32'd1);
        checkOutput("loss_unlocked", 32'(locked_a), 32'd0);
        checkOutput("loss_err_cnt", 32'(err_cnt_a), 32'd4);
        for (int i = 0; i < 5; i++) sendGood();
        checkOutput("relock", 32'(locked_a), 32'd1);
        checkOutput("relock_err_cnt", 32'(err_cnt_a), 32'd4);

        applyStimulus(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 3'b000);
        checkOutput("zeros_hunt", 32'(locked_a), 32'd0);
        gi = 0;
        for (int n = 0; n < 5; ) begin
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, 1'b0, 3'($urandom));
            end else begin
                if (n == 4) checkOutput("gap_not_yet", 32'(locked_a), 32'd0);
                sendGood();
                n++;
            end
        end
        checkOutput("gap_locked", 32'(locked_a), 32'd1);

        for (int i = 0; i < 3; i++) sendGood();
        sendBad();
        sendGood();
        sendBad();
        checkOutput("pre_reset_err_cnt", 32'(err_cnt_a), 32'd2);
        checkOutput("pre_reset_locked", 32'(locked_a), 32'd1);
        applyStimulus(1'b1, 1'b1, seq[gi]);
        checkOutput("mid_reset_locked", 32'(locked_a), 32'd0);
        checkOutput("mid_reset_err_cnt", 32'(err_cnt_a), 32'd0);
        for (int i = 0; i < 5; i++) sendGood();
        checkOutput("post_reset_relock", 32'(locked_a), 32'd1);

        for (int i = 0; i < 20; i++) sendBad();
        checkOutput("sat_err_cnt", 32'(err_cnt_b), 32'd15);
        checkOutput("sat_locked", 32'(locked_b), 32'd1);
        for (int i = 0; i < 8; i++) sendGood();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
